// File: rtl/alu_seq_pkg.sv
// Shared types for the execute-stage ALU: the command encoding and the set of
// commands that run on the iterative multiply/divide engine.
package Types;
    typedef logic [31:0] op_t;
endpackage

package ALUType;
    typedef enum logic [3:0] {
        AND         = 4'd0,
        OR          = 4'd1,
        XOR         = 4'd2,
        ADD         = 4'd3,
        SUB         = 4'd4,
        LESS_THAN   = 4'd5,
        LESS_THAN_U = 4'd6,
        EQUAL       = 4'd7,
        SLL         = 4'd8,
        SRL         = 4'd9,
        SRA         = 4'd10,
        MUL         = 4'd11,
        MULHU       = 4'd12,
        DIVU        = 4'd13,
        REMU        = 4'd14
    } alu_cmd_t;

    localparam int N_ITER_CMDS = 4;
    localparam alu_cmd_t ITER_CMDS [N_ITER_CMDS] = '{MUL, MULHU, DIVU, REMU};

    function automatic logic is_iter(input alu_cmd_t c);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_ITER_CMDS; i++) begin
            if (c == ITER_CMDS[i]) hit = 1'b1;
        end
        return hit;
    endfunction
endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the issue register, the ALU and
// the writeback register.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    import ALUType::*;

    logic             in_valid;
    logic             in_ready;
    alu_cmd_t         cmd;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, cmd, a, b, out_ready,
        input  in_ready, out_valid, out, overflow, zero
    );

    modport slave (
        input  in_valid, cmd, a, b, out_ready,
        output in_ready, out_valid, out, overflow, zero
    );
endinterface

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide engine, one bit per step on a
// shared WIDTH+1 adder. Only present when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module muldiv_iter
    import ALUType::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  alu_cmd_t         op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic             is_mul;
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [WIDTH:0]   add_x, add_y, sum;

    // Multiply: conditional add then shift {hi,lo} right. Divide: shift the
    // partial remainder left and subtract the divisor, restoring on borrow.
    always_comb begin
        add_x = is_mul ? {1'b0, hi} : {hi, lo[WIDTH-1]};
        add_y = is_mul ? (lo[0] ? {1'b0, opnd} : '0) : ~{1'b0, opnd};
        sum   = add_x + add_y + {{WIDTH{1'b0}}, ~is_mul};
        if (is_mul) begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end else if (!sum[WIDTH]) begin
            hi_nxt = sum[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_nxt = add_x[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            is_mul <= (op == MUL) || (op == MULHU);
            hi     <= '0;
            lo     <= ((op == MUL) || (op == MULHU)) ? b : a;
            opnd   <= ((op == MUL) || (op == MULHU)) ? a : b;
        end else if (step) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

    // Results are the post-step values so the final step lands directly in
    // the top-level result register.
    assign result_lo = lo_nxt;
    assign result_hi = hi_nxt;
    assign done      = (cnt == CW'(WIDTH - 1));
endmodule
`endif

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU with registered result. Define ALU_MULDIV_EN to
// add the iterative MUL/MULHU/DIVU/REMU engine; otherwise those decode as undefined.
module alu_seq
    import ALUType::*;
#(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             ovf;
    } res_t;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t           state, state_nxt;
    logic             accept;
    logic             ld_res;
    res_t             res_nxt;
    logic [WIDTH-1:0] out_p1;
    logic             ovf_p1;
    logic             zero_p1;

    function automatic res_t alu_single(input alu_cmd_t c, input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y);
        res_t                    r;
        logic [WIDTH:0]          ext;
        logic signed [WIDTH-1:0] xs, ys;
        logic [SHW-1:0]          sh;
        r   = '0;
        ext = '0;
        xs  = x;
        ys  = y;
        sh  = y[SHW-1:0];
        case (c)
            AND:         r.res = x & y;
            OR:          r.res = x | y;
            XOR:         r.res = x ^ y;
            ADD: begin
                ext   = {x[WIDTH-1], x} + {y[WIDTH-1], y};
                r.res = ext[WIDTH-1:0];
                r.ovf = ext[WIDTH] ^ ext[WIDTH-1];
            end
            SUB: begin
                ext   = {x[WIDTH-1], x} - {y[WIDTH-1], y};
                r.res = ext[WIDTH-1:0];
                r.ovf = ext[WIDTH] ^ ext[WIDTH-1];
            end
            LESS_THAN:   r.res = {{(WIDTH-1){1'b0}}, xs < ys};
            LESS_THAN_U: r.res = {{(WIDTH-1){1'b0}}, x < y};
            EQUAL:       r.res = {{(WIDTH-1){1'b0}}, x == y};
            SLL:         r.res = x << sh;
            SRL:         r.res = x >> sh;
            SRA:         r.res = $unsigned(xs >>> sh);
            default:     r = '0;
        endcase
        return r;
    endfunction

`ifdef ALU_MULDIV_EN
    logic             start, step, md_done;
    logic [WIDTH-1:0] md_lo, md_hi;
    alu_cmd_t         cmd_p0;
    logic             bz_p0;

    function automatic res_t iter_sel(input alu_cmd_t c, input logic [WIDTH-1:0] lo,
                                      input logic [WIDTH-1:0] hi, input logic bz);
        res_t r;
        r = '0;
        case (c)
            MUL:     begin r.res = lo; r.ovf = |hi; end
            MULHU:   r.res = hi;
            DIVU:    begin r.res = lo; r.ovf = bz; end
            REMU:    begin r.res = hi; r.ovf = bz; end
            default: r = '0;
        endcase
        return r;
    endfunction

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (bus.cmd),
        .a         (bus.a),
        .b         (bus.b),
        .step      (step),
        .result_lo (md_lo),
        .result_hi (md_hi),
        .done      (md_done)
    );

    // ---- p0: command and divide-by-zero flag captured at accept ----
    always_ff @(posedge clk) begin
        if (start) begin
            cmd_p0 <= bus.cmd;
            bz_p0  <= (bus.b == '0);
        end
    end
`endif

    assign bus.in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_nxt = state;
        ld_res    = 1'b0;
        res_nxt   = alu_single(bus.cmd, bus.a, bus.b);
`ifdef ALU_MULDIV_EN
        start     = 1'b0;
        step      = 1'b0;
`endif
        case (state)
            IDLE, DONE: begin
                if (accept) begin
`ifdef ALU_MULDIV_EN
                    if (is_iter(bus.cmd)) begin
                        state_nxt = ITER;
                        start     = 1'b1;
                    end else
`endif
                    begin
                        state_nxt = DONE;
                        ld_res    = 1'b1;
                    end
                end else if (state == DONE && bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
`ifdef ALU_MULDIV_EN
            ITER: begin
                step = 1'b1;
                if (md_done) begin
                    state_nxt = DONE;
                    ld_res    = 1'b1;
                    res_nxt   = iter_sel(cmd_p0, md_lo, md_hi, bz_p0);
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // ---- p1: result register, held while the consumer stalls ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out_p1  <= '0;
            ovf_p1  <= 1'b0;
            zero_p1 <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ld_res) begin
                out_p1  <= res_nxt.res;
                ovf_p1  <= res_nxt.ovf;
                zero_p1 <= (res_nxt.res == '0);
            end
        end
    end

    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_p1;
    assign bus.overflow  = ovf_p1;
    assign bus.zero      = zero_p1;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq; expectations adapt to whether ALU_MULDIV_EN is defined.
module tb_alu_seq;
    import ALUType::*;

    localparam int W = 32;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic seen;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request with out_ready high, measure cycles to out_valid, check result.
    task automatic run_op(input string tag, input alu_cmd_t c, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eo, input logic eov,
                          input int elat);
        int lat;
        bus.cmd       = c;
        bus.a         = x;
        bus.b         = y;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.a        = '1;
        bus.b        = '0;
        bus.cmd      = ADD;
        lat          = 1;
        if (!bus.out_valid) chk({tag, ".busy_in_ready"}, 32'(bus.in_ready), 32'd0);
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(elat));
        chk({tag, ".out"}, bus.out, eo);
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(eov));
        chk({tag, ".zero"}, 32'(bus.zero), 32'(eo == 32'd0));
        tick();
        chk({tag, ".emitted"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.cmd       = ADD;
        bus.a         = '0;
        bus.b         = '0;
        seen          = 1'b0;
        tick();
        tick();
        tick();
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.out", bus.out, 32'd0);
        chk("rst.overflow", 32'(bus.overflow), 32'd0);
        chk("rst.zero", 32'(bus.zero), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);

        // ADD signed overflow, result held with out_ready low
        bus.cmd      = ADD;
        bus.a        = 32'h7FFF_FFFF;
        bus.b        = 32'h0000_0001;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("add.out_valid", 32'(bus.out_valid), 32'd1);
        chk("add.out", bus.out, 32'h8000_0000);
        chk("add.overflow", 32'(bus.overflow), 32'd1);
        chk("add.zero", 32'(bus.zero), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("add.emitted", 32'(bus.out_valid), 32'd0);

        // Back-to-back SUB then SLL at full throughput
        bus.cmd      = SUB;
        bus.a        = 32'd5;
        bus.b        = 32'd5;
        bus.in_valid = 1'b1;
        #1;
        chk("b2b.in_ready0", 32'(bus.in_ready), 32'd1);
        tick();
        chk("b2b.sub_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b.sub_out", bus.out, 32'd0);
        chk("b2b.sub_zero", 32'(bus.zero), 32'd1);
        bus.cmd = SLL;
        bus.a   = 32'd1;
        bus.b   = 32'd33;
        #1;
        chk("b2b.in_ready1", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b.sll_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b.sll_out", bus.out, 32'd2);
        chk("b2b.sll_zero", 32'(bus.zero), 32'd0);
        tick();
        chk("b2b.emitted", 32'(bus.out_valid), 32'd0);

        // Stall: XOR result held for 3 cycles while the next request waits
        bus.out_ready = 1'b0;
        bus.cmd       = XOR;
        bus.a         = 32'hF0F0_F0F0;
        bus.b         = 32'hFF00_FF00;
        bus.in_valid  = 1'b1;
        tick();
        bus.cmd = LESS_THAN;
        bus.a   = 32'hFFFF_FFFF;
        bus.b   = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            chk("hold.out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold.out", bus.out, 32'h0FF0_0FF0);
            chk("hold.overflow", 32'(bus.overflow), 32'd0);
            chk("hold.zero", 32'(bus.zero), 32'd0);
            chk("hold.in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("hold.release_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("hold.lt_valid", 32'(bus.out_valid), 32'd1);
        chk("hold.lt_out", bus.out, 32'd1);
        tick();
        chk("hold.emitted", 32'(bus.out_valid), 32'd0);

        // Remaining single-cycle commands
        run_op("sub_ovf", SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1);
        run_op("add_neg", ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1);
        run_op("ltu", LESS_THAN_U, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
        run_op("eq", EQUAL, 32'd7, 32'd7, 32'd1, 1'b0, 1);
        run_op("sra", SRA, 32'h8000_0000, 32'hFFFF_FFE4, 32'hF800_0000, 1'b0, 1);
        run_op("srl", SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1);
        run_op("or", OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1);
        run_op("and", AND, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0F00, 1'b0, 1);
        run_op("undef", alu_cmd_t'(4'hF), 32'd5, 32'd5, 32'd0, 1'b0, 1);

        // Iterative commands (undefined encodings when the engine is absent)
        run_op("mul", MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, MD, MD ? 33 : 1);
        run_op("mulhu", MULHU, 32'h0001_0000, 32'h0001_0000, MD ? 32'd1 : 32'd0, 1'b0,
               MD ? 33 : 1);
        run_op("divu", DIVU, 32'd100, 32'd7, MD ? 32'd14 : 32'd0, 1'b0, MD ? 33 : 1);
        run_op("remu", REMU, 32'd100, 32'd7, MD ? 32'd2 : 32'd0, 1'b0, MD ? 33 : 1);
        run_op("divu0", DIVU, 32'd12345, 32'd0, MD ? 32'hFFFF_FFFF : 32'd0, MD, MD ? 33 : 1);
        run_op("remu0", REMU, 32'd12345, 32'd0, MD ? 32'd12345 : 32'd0, MD, MD ? 33 : 1);

        // Reset while a DIVU is in flight discards it
        bus.out_ready = 1'b0;
        bus.cmd       = DIVU;
        bus.a         = 32'd100;
        bus.b         = 32'd7;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rstmid.in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        chk("rstmid.no_result", 32'(seen), 32'd0);
        run_op("post_rst_add", ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational execute-stage ALU. Single-cycle ops return a registered result one cycle after acceptance. With the multiply/divide option compiled in, an iterative engine runs unsigned multiply and divide in WIDTH+1 cycles. Sits in the execute stage between the issue register and the writeback register, and back-pressures issue while busy.

## Interface
- WIDTH, 32: operand/result width. Must be a power of two, ≥ 8.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  a, b and cmd are valid.
- in_ready  out  1  block accepts the request this cycle.
- cmd  in  ALUType::alu_cmd_t  operation.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result.
- overflow  out  1  per-command overflow flag, registered with out.
- zero  out  1  out == 0, registered with out.

## Operation
- Accept on in_valid && in_ready. Emit on out_valid && out_ready.
- FSM states:
  - IDLE: no result held.
  - ITER: engine running.
  - DONE: result held.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Same-cycle accept and emit is legal.
- Single-cycle command accepted: next state DONE.
- Iterative command accepted: next state ITER, iteration count = 0.
- ITER: one step per cycle. When the count reaches WIDTH-1, go to DONE. in_ready = 0 throughout ITER.
- DONE: if out_ready and there is no new accept, go to IDLE.
- Commands:
  - AND, OR, XOR (a^b).
  - ADD, SUB: overflow = signed overflow, computed on a WIDTH+1 sign-extended result (MSB ^ MSB-1).
  - LESS_THAN: signed. LESS_THAN_U: unsigned. EQUAL. Each returns 0 or 1, zero-extended.
  - SLL, SRL, SRA: shift amount = b[$clog2(WIDTH)-1:0]; upper bits of b are ignored.
  - MUL: low WIDTH bits of the unsigned product; overflow = 1 if the high half ≠ 0.
  - MULHU: high WIDTH bits of the unsigned product.
  - DIVU, REMU: restoring division. b == 0 gives quotient all-ones, remainder = a, overflow = 1.
  - Undefined encodings: out = 0, overflow = 0, single-cycle.
- overflow = 0 for every command not listed above as setting it.
- Inputs are sampled only on accept. Changes to a, b and cmd after accept have no effect.

## Timing
- Reset values: state IDLE, out_valid 0, out 0, overflow 0, zero 0, iteration count 0. in_ready = 1 in the first cycle after rst deasserts.
- rst mid-ITER or in DONE: the operation and held result are discarded and no result is emitted.
- Single-cycle latency is 1: accept at edge N, out_valid at N+1.
- Throughput is 1 per cycle when out_ready is held high.
- Iterative latency: accept at edge N, out_valid at N+WIDTH+1 (WIDTH steps plus result register).
- While out_valid && !out_ready: out, overflow and zero are stable and in_ready = 0.
- in_valid arriving while in ITER is not accepted. The issuer keeps it asserted.

## Configuration
- ALU_MULDIV_EN:
  - Defined: iterative engine and the MUL, MULHU, DIVU, REMU commands are present.
  - Undefined: no engine and no ITER state. Those four commands behave as undefined encodings: single-cycle, out = 0, overflow = 0.

## Structure
- ALUType package holds alu_cmd_t, extended with XOR, LESS_THAN_U, SRA, MUL, MULHU, DIVU, REMU, and a localparam list of iterative commands.
- Types::op_t stays the 32-bit default.
- Sub-module muldiv_iter, instantiated only under ALU_MULDIV_EN:
  - Shift-add multiplier and restoring divider sharing one WIDTH+1 adder.
  - Ports: start, op, a, b, step, result_lo, result_hi, done.
- The top level owns the FSM, handshake and result register.

## Test plan
- Reset then ADD a=0x7FFFFFFF, b=1 → out=0x80000000, overflow=1, zero=0, out_valid one cycle after accept.
- Back-to-back SUB 5-5 then SLL 1<<33 with out_ready=1 → zero=1, then out=2; in_ready stays 1 every cycle.
- Result held with out_ready=0 for 3 cycles → out, overflow and zero stable; in_ready=0; next request accepted in the cycle out_ready rises.
- MUL 0x10000×0x10000 → out=0, overflow=1 after exactly 33 cycles. MULHU same operands → 1.
- DIVU 100/7 → 14. REMU 100/7 → 2. DIVU x/0 → 0xFFFFFFFF, overflow=1.
- rst asserted mid-DIVU → no out_valid. After reset, ADD 1+1 → 2.
